// File: rtl/imem_stream_loader.sv
// -----------------------------------------------------------------------------
// imem_stream_loader
//
// Writer side of the instruction memory. Takes a byte stream over a
// valid/ready handshake, packs it little-endian into 32-bit words and issues
// one word write (byte address, data, byte strobes) per completed or
// terminated word. The core is held in reset while an image is loading and is
// released once the image is complete.
//
// Optional build macro:
//   IMEM_STREAM_LOADER_CSUM_EN - when defined, csum is the running sum
//                                (mod 256) of all accepted bytes; when
//                                undefined, csum is tied to 0.
//
// Parameters:
//   ADDR_W     byte-address width of the instruction memory
//   MEM_BYTES  capacity in bytes (multiple of 4, <= 2**ADDR_W)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse that begins a load (ignored in LOAD)
//   s_valid/s_data/
//   s_last/s_ready      byte stream handshake; s_last marks the final byte
//   w_en                one-cycle word write strobe
//   w_addr/w_data/
//   w_strb              word-aligned byte address, data, lane enables
//   byte_count          bytes accepted in the current load
//   busy / done         in LOAD / in DONE
//   err                 sticky overflow flag (capacity hit without s_last)
//   core_rst_n          active-low reset to the core
//   csum                stream checksum (see macro above)
// -----------------------------------------------------------------------------
module imem_stream_loader #(
  parameter int ADDR_W    = 7,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_data,
  output logic [3:0]        w_strb,
  output logic [7:0]        byte_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_rst_n,
  output logic [7:0]        csum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [8:0] CAPACITY = 9'(MEM_BYTES);

  state_t state, state_nxt;

  // Word assembly buffer, next free lane, and address of the word being built.
  logic [31:0]       asm_buf;
  logic [3:0]        asm_strb;
  logic [1:0]        ptr;
  logic [ADDR_W-1:0] word_base;

  logic        accept;
  logic        start_load;
  logic [8:0]  count_nxt;
  logic        at_capacity;
  logic        flush;
  logic [31:0] buf_nxt;
  logic [3:0]  strb_nxt;

  // start is honoured from IDLE or DONE only.
  assign start_load  = start && (state != ST_LOAD);
  assign accept      = (state == ST_LOAD) && s_valid;
  assign count_nxt   = {1'b0, byte_count} + 9'd1;
  assign at_capacity = (count_nxt == CAPACITY);
  assign flush       = accept && ((ptr == 2'd3) || s_last || at_capacity);

  // Merge the incoming byte into its lane of the assembly buffer.
  always_comb begin
    // NOTE: every always_comb output gets a default first; without it a path
    // that skips an assignment infers a latch.
    buf_nxt  = asm_buf;
    strb_nxt = asm_strb | (4'b0001 << ptr);
    for (int k = 0; k < 4; k++) begin
      if (ptr == 2'(k)) buf_nxt[8*k +: 8] = s_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: if (accept && (s_last || at_capacity)) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: state-decoded outputs. core_rst_n follows the state register, so it
  // drops on the same edge that re-enters LOAD from DONE.
  always_comb begin
    s_ready    = (state == ST_LOAD);
    busy       = (state == ST_LOAD);
    done       = (state == ST_DONE);
    core_rst_n = (state == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: byte packing, write port, counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // A partially assembled word is dropped here and never written.
      asm_buf    <= '0;
      asm_strb   <= '0;
      ptr        <= '0;
      word_base  <= '0;
      byte_count <= '0;
      err        <= 1'b0;
      w_en       <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
    end else begin
      w_en <= 1'b0;
      if (start_load) begin
        // Write-port registers keep the last write; only load state clears.
        asm_buf    <= '0;
        asm_strb   <= '0;
        ptr        <= '0;
        word_base  <= '0;
        byte_count <= '0;
        err        <= 1'b0;
      end else if (accept) begin
        byte_count <= count_nxt[7:0];
        if (at_capacity && !s_last) err <= 1'b1;
        if (flush) begin
          // Emit the word and clear the buffer on the same edge so the next
          // byte can land in lane 0 without a stall.
          w_en      <= 1'b1;
          w_addr    <= word_base;
          w_data    <= buf_nxt;
          w_strb    <= strb_nxt;
          word_base <= word_base + ADDR_W'(4);
          asm_buf   <= '0;
          asm_strb  <= '0;
          ptr       <= '0;
        end else begin
          asm_buf  <= buf_nxt;
          asm_strb <= strb_nxt;
          ptr      <= ptr + 2'd1;
        end
      end
    end
  end

`ifdef IMEM_STREAM_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          csum <= '0;
    else if (start_load) csum <= '0;
    else if (accept)     csum <= csum + s_data;
  end
`else
  assign csum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_stream_loader
//
// Directed self-checking bench for imem_stream_loader. A monitor records every
// word write; the directed sequence compares those records and the status
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_stream_loader;

  localparam int ADDR_W    = 7;
  localparam int MEM_BYTES = 128;

`ifdef IMEM_STREAM_LOADER_CSUM_EN
  localparam logic [7:0] EXP_CSUM = 8'h10;
`else
  localparam logic [7:0] EXP_CSUM = 8'h00;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [7:0]        byte_count;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_rst_n;
  logic [7:0]        csum;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] wr_strb_q[$];

  imem_stream_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .w_strb     (w_strb),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_rst_n (core_rst_n),
    .csum       (csum)
  );

  always #5 clk = ~clk;

  // Record each write 1 ns after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (w_en === 1'b1) begin
      wr_addr_q.push_back(32'(w_addr));
      wr_data_q.push_back(w_data);
      wr_strb_q.push_back(32'(w_strb));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_strb_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".w_en"},       32'(w_en),       32'h0);
    check({tag, ".w_addr"},     32'(w_addr),     32'h0);
    check({tag, ".w_data"},     w_data,          32'h0);
    check({tag, ".w_strb"},     32'(w_strb),     32'h0);
    check({tag, ".byte_count"}, 32'(byte_count), 32'h0);
    check({tag, ".busy"},       32'(busy),       32'h0);
    check({tag, ".done"},       32'(done),       32'h0);
    check({tag, ".err"},        32'(err),        32'h0);
    check({tag, ".core_rst_n"}, 32'(core_rst_n), 32'h0);
    check({tag, ".csum"},       32'(csum),       32'h0);
    check({tag, ".s_ready"},    32'(s_ready),    32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;

    // ---- Reset state ----
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_idle_outputs("idle");

    // ---- Load 01..08, last on 08 ----
    clear_log();
    pulse_start();
    check("t1.busy",       32'(busy),       32'h1);
    check("t1.s_ready",    32'(s_ready),    32'h1);
    check("t1.core_rst_n", 32'(core_rst_n), 32'h0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    check("t1.w_en_last",  32'(w_en),       32'h1);
    check("t1.done",       32'(done),       32'h1);
    tick();
    check("t1.w_en_drop",  32'(w_en),       32'h0);
    check("t1.w_addr_hold",32'(w_addr),     32'h4);
    check("t1.nwrites",    32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("t1.addr0", wr_addr_q[0], 32'h0);
      check("t1.data0", wr_data_q[0], 32'h04030201);
      check("t1.strb0", wr_strb_q[0], 32'hF);
      check("t1.addr1", wr_addr_q[1], 32'h4);
      check("t1.data1", wr_data_q[1], 32'h08070605);
      check("t1.strb1", wr_strb_q[1], 32'hF);
    end
    check("t1.core_rst_n_done", 32'(core_rst_n), 32'h1);
    check("t1.byte_count", 32'(byte_count), 32'd8);
    check("t1.err",        32'(err),        32'h0);
    check("t1.s_ready_done", 32'(s_ready),  32'h0);

    // ---- Restart from DONE, load AA..AF ----
    clear_log();
    pulse_start();
    check("t2.core_rst_n", 32'(core_rst_n), 32'h0);
    check("t2.busy",       32'(busy),       32'h1);
    check("t2.byte_count", 32'(byte_count), 32'h0);
    check("t2.err",        32'(err),        32'h0);
    for (int i = 0; i < 6; i++) send_byte(8'hAA + 8'(i), i == 5);
    tick();
    check("t2.nwrites", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("t2.data0", wr_data_q[0], 32'hADACABAA);
      check("t2.addr1", wr_addr_q[1], 32'h4);
      check("t2.data1", wr_data_q[1], 32'h0000AFAE);
      check("t2.strb1", wr_strb_q[1], 32'h3);
    end
    check("t2.byte_count_end", 32'(byte_count), 32'd6);
    check("t2.done", 32'(done), 32'h1);

    // ---- Overflow: 128 bytes with no s_last ----
    clear_log();
    pulse_start();
    for (int i = 0; i < MEM_BYTES; i++) send_byte(8'(i), 1'b0);
    tick();
    check("t3.nwrites", 32'(wr_addr_q.size()), 32'd32);
    if (wr_addr_q.size() == 32) begin
      check("t3.addr_last", wr_addr_q[31], 32'd124);
      check("t3.data_last", wr_data_q[31], 32'h7F7E7D7C);
      check("t3.strb_last", wr_strb_q[31], 32'hF);
    end
    check("t3.err",     32'(err),     32'h1);
    check("t3.done",    32'(done),    32'h1);
    check("t3.s_ready", 32'(s_ready), 32'h0);
    send_byte(8'h5A, 1'b0);
    tick();
    check("t3.byte_count_129", 32'(byte_count), 32'd128);
    check("t3.nwrites_129",    32'(wr_addr_q.size()), 32'd32);

    // ---- Reset mid-load, then idle stream noise ----
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'h11 * 8'(i + 1), 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t4.async_rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = i[0];
      s_data  = 8'hE0 + 8'(i);
      s_last  = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    check("t4.nwrites_idle",   32'(wr_addr_q.size()), 32'd0);
    check("t4.byte_count_idle", 32'(byte_count), 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b0);
    tick();
    check("t4.nwrites_reload", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("t4.addr0", wr_addr_q[0], 32'h0);
      check("t4.data0", wr_data_q[0], 32'h24232221);
    end

    // ---- Checksum stream FF,01,10 ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    pulse_start();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b1);
    tick();
    check("t5.csum", 32'(csum), 32'(EXP_CSUM));
    check("t5.nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("t5.data0", wr_data_q[0], 32'h001001FF);
      check("t5.strb0", wr_strb_q[0], 32'h7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
